// File: rtl/load_scheduler_pkg.sv
// Shared definitions for the time/alarm load path: FSM states, target and
// requester encodings, and the BCD limits of a 24-hour HH:MM value.
package load_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic TGT_CEAS   = 1'b0;
  localparam logic TGT_ALARMA = 1'b1;

  localparam logic REQ_C = 1'b0;
  localparam logic REQ_U = 1'b1;

  localparam int H10_MAX      = 2;
  localparam int H1_MAX_AT_20 = 3;
  localparam int M10_MAX      = 5;
  localparam int DIG_MAX      = 9;

endpackage

// File: rtl/load_scheduler_bcd_time_check.sv
// Combinational range check of a packed BCD HH:MM word {H10,H1,M10,M1}.
module bcd_time_check
  import load_scheduler_pkg::*;
#(
  parameter int DIG_W = 4
) (
  input  logic [4*DIG_W-1:0] dig_i,
  output logic               valid_o
);

  logic [DIG_W-1:0] h10;
  logic [DIG_W-1:0] h1;
  logic [DIG_W-1:0] m10;
  logic [DIG_W-1:0] m1;

  assign h10 = dig_i[4*DIG_W-1 -: DIG_W];
  assign h1  = dig_i[3*DIG_W-1 -: DIG_W];
  assign m10 = dig_i[2*DIG_W-1 -: DIG_W];
  assign m1  = dig_i[DIG_W-1   -: DIG_W];

  // Hours 20..23 are the only case where H1 is limited below 9.
  assign valid_o = (h10 <= DIG_W'(H10_MAX))
                && (h1  <= DIG_W'(DIG_MAX))
                && ((h10 != DIG_W'(H10_MAX)) || (h1 <= DIG_W'(H1_MAX_AT_20)))
                && (m10 <= DIG_W'(M10_MAX))
                && (m1  <= DIG_W'(DIG_MAX));

endmodule

// File: rtl/load_scheduler.sv
// Round-robin arbiter between control-FSM and UART load requests, driving one
// shared BCD HH:MM bus into the clock counter or the alarm register.
module load_scheduler
  import load_scheduler_pkg::*;
#(
  parameter int DIG_W    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               req_c,
  input  logic               tgt_c,
  input  logic [4*DIG_W-1:0] dig_c,
  input  logic               req_u,
  input  logic               tgt_u,
  input  logic [4*DIG_W-1:0] dig_u,
  output logic [4*DIG_W-1:0] o_dig,
  output logic               load_ceas,
  output logic               load_alarma,
  output logic               ack_c,
  output logic               ack_u,
  output logic               err_c,
  output logic               err_u,
  output logic               ovr_c,
  output logic               ovr_u,
  output logic               busy
);

  localparam int BUS_W = 4 * DIG_W;
  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_e             state_q, state_d;
  logic [BUS_W:0]     hold_c_q, hold_c_d;
  logic [BUS_W:0]     hold_u_q, hold_u_d;
  logic               pend_c_q, pend_c_d;
  logic               pend_u_q, pend_u_d;
  logic               ovr_c_q, ovr_c_d;
  logic               ovr_u_q, ovr_u_d;
  logic [BUS_W:0]     work_q, work_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BUS_W-1:0]   out_q, out_d;
  logic               grant_c;
  logic               grant_u;
  logic               work_ok;

  bcd_time_check #(.DIG_W(DIG_W)) u_check (
    .dig_i   (work_q[BUS_W-1:0]),
    .valid_o (work_ok)
  );

  always_comb begin
    state_d  = state_q;
    hold_c_d = hold_c_q;
    hold_u_d = hold_u_q;
    pend_c_d = pend_c_q;
    pend_u_d = pend_u_q;
    ovr_c_d  = ovr_c_q;
    ovr_u_d  = ovr_u_q;
    work_d   = work_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    grant_c  = 1'b0;
    grant_u  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // With both pending, the requester not served last wins.
        if (pend_c_q && pend_u_q) begin
          if (last_q == REQ_U) grant_c = 1'b1;
          else                 grant_u = 1'b1;
        end else if (pend_c_q) begin
          grant_c = 1'b1;
        end else if (pend_u_q) begin
          grant_u = 1'b1;
        end
        if (grant_c || grant_u) begin
          work_d  = grant_c ? hold_c_q : hold_u_q;
          gnt_d   = grant_u ? REQ_U : REQ_C;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (work_ok) begin
          state_d = ST_LOAD;
          out_d   = work_q[BUS_W-1:0];
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = ST_DONE;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new request in the same edge as its own grant re-arms pend without
    // counting as an overwrite: the old data has just been taken.
    if (req_c) begin
      hold_c_d = {tgt_c, dig_c};
      pend_c_d = 1'b1;
      if (pend_c_q && !grant_c) ovr_c_d = 1'b1;
    end else if (grant_c) begin
      pend_c_d = 1'b0;
    end

    if (req_u) begin
      hold_u_d = {tgt_u, dig_u};
      pend_u_d = 1'b1;
      if (pend_u_q && !grant_u) ovr_u_d = 1'b1;
    end else if (grant_u) begin
      pend_u_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= ST_IDLE;
      hold_c_q <= '0;
      hold_u_q <= '0;
      pend_c_q <= 1'b0;
      pend_u_q <= 1'b0;
      ovr_c_q  <= 1'b0;
      ovr_u_q  <= 1'b0;
      work_q   <= '0;
      gnt_q    <= REQ_C;
      last_q   <= REQ_U;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_c_q <= hold_c_d;
      hold_u_q <= hold_u_d;
      pend_c_q <= pend_c_d;
      pend_u_q <= pend_u_d;
      ovr_c_q  <= ovr_c_d;
      ovr_u_q  <= ovr_u_d;
      work_q   <= work_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign o_dig       = out_q;
  assign load_ceas   = (state_q == ST_LOAD) && (work_q[BUS_W] == TGT_CEAS);
  assign load_alarma = (state_q == ST_LOAD) && (work_q[BUS_W] == TGT_ALARMA);
  assign ack_c       = (state_q == ST_DONE) && (gnt_q == REQ_C);
  assign ack_u       = (state_q == ST_DONE) && (gnt_q == REQ_U);
  assign err_c       = ack_c && err_q;
  assign err_u       = ack_u && err_q;
  assign ovr_c       = ovr_c_q;
  assign ovr_u       = ovr_u_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_load_scheduler.sv
// Directed and randomized bench for load_scheduler: a transaction-level model
// predicts acks, errors, loaded words, strobe lengths and latency.
module tb_load_scheduler;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset_;
  logic        req_c, tgt_c, req_u, tgt_u;
  logic [15:0] dig_c, dig_u;
  logic [15:0] o_dig;
  logic        load_ceas, load_alarma, ack_c, ack_u, err_c, err_u, ovr_c, ovr_u, busy;

  always #5 clk = ~clk;

  load_scheduler #(.DIG_W(4), .HOLD_CYC(HOLD)) dut (
    .clk         (clk),
    .reset_      (reset_),
    .req_c       (req_c),
    .tgt_c       (tgt_c),
    .dig_c       (dig_c),
    .req_u       (req_u),
    .tgt_u       (tgt_u),
    .dig_u       (dig_u),
    .o_dig       (o_dig),
    .load_ceas   (load_ceas),
    .load_alarma (load_alarma),
    .ack_c       (ack_c),
    .ack_u       (ack_u),
    .err_c       (err_c),
    .err_u       (err_u),
    .ovr_c       (ovr_c),
    .ovr_u       (ovr_u),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, written only by the monitor.
  bit          ld_tgt_q[$];
  logic [15:0] ld_dig_q[$];
  int          ld_cyc_q[$];
  bit          ack_who_q[$];
  bit          ack_err_q[$];
  int          ack_cyc_q[$];
  int          ld_c_n = 0;
  int          ld_a_n = 0;
  int          viol = 0;
  int          rises = 0;
  logic        prev_strb = 1'b0;
  logic        prev_busy = 1'b0;
  logic [15:0] prev_dig = '0;

  always @(negedge clk) begin
    if (!reset_) begin
      rises     <= 0;
      prev_strb <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (load_ceas)   ld_c_n <= ld_c_n + 1;
      if (load_alarma) ld_a_n <= ld_a_n + 1;
      if (load_ceas && load_alarma) viol <= viol + 1;
      if ((load_ceas || load_alarma) && !prev_strb) begin
        ld_tgt_q.push_back(load_alarma);
        ld_dig_q.push_back(o_dig);
        ld_cyc_q.push_back(cyc);
      end
      if ((load_ceas || load_alarma) && prev_strb && (o_dig !== prev_dig)) viol <= viol + 1;
      if ((err_c && !ack_c) || (err_u && !ack_u) || (ack_c && ack_u)) viol <= viol + 1;
      // Every ack must follow exactly one grant (busy rising from idle).
      if (ack_c || ack_u) begin
        if (rises != 1) viol <= viol + 1;
        rises <= 0;
        ack_who_q.push_back(ack_u);
        ack_err_q.push_back(ack_u ? err_u : err_c);
        ack_cyc_q.push_back(cyc);
      end else if (busy && !prev_busy) begin
        rises <= rises + 1;
      end
      prev_strb <= load_ceas || load_alarma;
      prev_busy <= busy;
      prev_dig  <= o_dig;
    end
  end

  // Reference model state.
  bit          last_gnt = 1'b1;
  logic [15:0] last_loaded = '0;
  bit          ovr_c_m = 1'b0;
  bit          ovr_u_m = 1'b0;

  function automatic bit bcd_ok(input logic [15:0] d);
    int h10, h1, m10, m1;
    h10 = int'(d[15:12]);
    h1  = int'(d[11:8]);
    m10 = int'(d[7:4]);
    m1  = int'(d[3:0]);
    return (h1 < 10) && (m10 < 10) && (m1 < 10)
        && ((h10 * 10 + h1) < 24) && ((m10 * 10 + m1) < 60);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic single(input bit who, input bit tgt, input logic [15:0] dig);
    int na0, nl0, ldc0, lda0, n;
    bit ok;
    na0  = ack_who_q.size();
    nl0  = ld_tgt_q.size();
    ldc0 = ld_c_n;
    lda0 = ld_a_n;
    ok   = bcd_ok(dig);
    @(posedge clk); #1;
    n = cyc;
    if (who) begin req_u = 1'b1; tgt_u = tgt; dig_u = dig; end
    else     begin req_c = 1'b1; tgt_c = tgt; dig_c = dig; end
    @(posedge clk); #1;
    req_c = 1'b0;
    req_u = 1'b0;
    for (int i = 0; i < 30 && ack_who_q.size() == na0; i++) wait_neg();
    repeat (3) wait_neg();
    last_gnt = who;
    if (ok) last_loaded = dig;
    $display("txn req=%s tgt=%0d dig=%04h expect_valid=%0d acks=%0d", who ? "U" : "C", tgt, dig, ok,
             ack_who_q.size() - na0);
    chk("ack_count", ack_who_q.size() - na0, 1);
    if (ack_who_q.size() > na0) begin
      chk("ack_who", ack_who_q[na0], who);
      chk("ack_err", ack_err_q[na0], !ok);
      chk("ack_latency", ack_cyc_q[na0] - n, ok ? 3 + HOLD : 3);
    end
    chk("ceas_cycles", ld_c_n - ldc0, (ok && tgt == 1'b0) ? HOLD : 0);
    chk("alarma_cycles", ld_a_n - lda0, (ok && tgt == 1'b1) ? HOLD : 0);
    chk("load_count", ld_tgt_q.size() - nl0, ok ? 1 : 0);
    if (ok && ld_tgt_q.size() > nl0) begin
      chk("load_dig", ld_dig_q[nl0], dig);
      chk("load_latency", ld_cyc_q[nl0] - n, 3);
    end
    chk("o_dig_hold", o_dig, last_loaded);
    chk("ovr_flags", {ovr_c, ovr_u}, {ovr_c_m, ovr_u_m});
    chk("busy_idle", busy, 0);
  endtask

  task automatic pair(input logic [15:0] dc, input logic [15:0] du);
    int na0, nl0, ldc0;
    bit first;
    first = (last_gnt == 1'b1) ? 1'b0 : 1'b1;
    na0  = ack_who_q.size();
    nl0  = ld_tgt_q.size();
    ldc0 = ld_c_n;
    @(posedge clk); #1;
    req_c = 1'b1; tgt_c = 1'b0; dig_c = dc;
    req_u = 1'b1; tgt_u = 1'b0; dig_u = du;
    @(posedge clk); #1;
    req_c = 1'b0;
    req_u = 1'b0;
    for (int i = 0; i < 60 && ack_who_q.size() < na0 + 2; i++) wait_neg();
    repeat (3) wait_neg();
    last_gnt    = !first;
    last_loaded = first ? dc : du;
    $display("txn pair c=%04h u=%04h first=%s acks=%0d", dc, du, first ? "U" : "C", ack_who_q.size() - na0);
    chk("pair_ack_count", ack_who_q.size() - na0, 2);
    if (ack_who_q.size() >= na0 + 2) begin
      chk("pair_first", ack_who_q[na0], first);
      chk("pair_second", ack_who_q[na0 + 1], !first);
    end
    chk("pair_load_count", ld_tgt_q.size() - nl0, 2);
    if (ld_tgt_q.size() >= nl0 + 2) begin
      chk("pair_dig_first", ld_dig_q[nl0], first ? du : dc);
      chk("pair_dig_second", ld_dig_q[nl0 + 1], first ? dc : du);
    end
    chk("pair_ceas_cycles", ld_c_n - ldc0, 2 * HOLD);
    chk("pair_o_dig", o_dig, last_loaded);
  endtask

  int          na_s, nl_s, ldc_s;
  bit          r_who, r_tgt;
  logic [15:0] r_dig;
  int          r_h, r_m;

  initial begin
    reset_ = 1'b0;
    req_c = 1'b0; tgt_c = 1'b0; dig_c = '0;
    req_u = 1'b0; tgt_u = 1'b0; dig_u = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_low",
        {o_dig, load_ceas, load_alarma, ack_c, ack_u, err_c, err_u, ovr_c, ovr_u, busy}, '0);
    reset_ = 1'b1;
    repeat (2) wait_neg();
    chk("idle_outputs_low",
        {o_dig, load_ceas, load_alarma, ack_c, ack_u, err_c, err_u, ovr_c, ovr_u, busy}, '0);

    single(1'b0, 1'b0, 16'h1234);
    single(1'b1, 1'b1, 16'h2460);
    single(1'b1, 1'b1, 16'h2359);

    pair(16'h0800, 16'h0930);
    single(1'b0, 1'b1, 16'h0715);
    pair(16'h0800, 16'h0930);

    // Two UART requests while busy with a C load: only the latest survives.
    na_s = ack_who_q.size();
    nl_s = ld_tgt_q.size();
    @(posedge clk); #1;
    req_c = 1'b1; tgt_c = 1'b0; dig_c = 16'h1111;
    @(posedge clk); #1;
    req_c = 1'b0;
    req_u = 1'b1; tgt_u = 1'b0; dig_u = 16'h0100;
    @(posedge clk); #1;
    dig_u = 16'h0200;
    @(posedge clk); #1;
    req_u = 1'b0;
    for (int i = 0; i < 60 && ack_who_q.size() < na_s + 2; i++) wait_neg();
    repeat (4) wait_neg();
    ovr_u_m = 1'b1;
    last_gnt = 1'b1;
    last_loaded = 16'h0200;
    $display("txn overwrite c=1111 u=0100,0200 acks=%0d loads=%0d", ack_who_q.size() - na_s,
             ld_tgt_q.size() - nl_s);
    chk("ovr_ack_count", ack_who_q.size() - na_s, 2);
    chk("ovr_load_count", ld_tgt_q.size() - nl_s, 2);
    if (ld_tgt_q.size() >= nl_s + 2) begin
      chk("ovr_dig_c", ld_dig_q[nl_s], 16'h1111);
      chk("ovr_dig_u", ld_dig_q[nl_s + 1], 16'h0200);
    end
    chk("ovr_flags_set", {ovr_c, ovr_u}, {ovr_c_m, ovr_u_m});
    single(1'b0, 1'b0, 16'h1905);

    // Asynchronous reset in the middle of a load, with a UART request queued.
    @(posedge clk); #1;
    req_c = 1'b1; tgt_c = 1'b0; dig_c = 16'h1234;
    @(posedge clk); #1;
    req_c = 1'b0;
    req_u = 1'b1; tgt_u = 1'b1; dig_u = 16'h0345;
    @(posedge clk); #1;
    req_u = 1'b0;
    for (int i = 0; i < 20 && !load_ceas; i++) wait_neg();
    chk("abort_load_seen", load_ceas, 1);
    reset_ = 1'b0;
    #1;
    chk("abort_strobe_drop", load_ceas, 0);
    chk("abort_busy", busy, 0);
    na_s  = ack_who_q.size();
    nl_s  = ld_tgt_q.size();
    ldc_s = ld_c_n;
    repeat (2) @(posedge clk);
    #3;
    reset_ = 1'b1;
    repeat (10) wait_neg();
    last_gnt = 1'b1;
    last_loaded = '0;
    ovr_c_m = 1'b0;
    ovr_u_m = 1'b0;
    $display("txn reset_mid_load acks_after=%0d loads_after=%0d", ack_who_q.size() - na_s,
             ld_tgt_q.size() - nl_s);
    chk("abort_no_ack", ack_who_q.size() - na_s, 0);
    chk("abort_no_load", ld_tgt_q.size() - nl_s, 0);
    chk("abort_no_ceas", ld_c_n - ldc_s, 0);
    chk("abort_outputs_low",
        {o_dig, load_ceas, load_alarma, ack_c, ack_u, err_c, err_u, ovr_c, ovr_u, busy}, '0);

    for (int t = 0; t < 40; t++) begin
      r_who = 1'($urandom_range(1, 0));
      r_tgt = 1'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 1) begin
        r_h   = int'($urandom_range(23, 0));
        r_m   = int'($urandom_range(59, 0));
        r_dig = {4'(r_h / 10), 4'(r_h % 10), 4'(r_m / 10), 4'(r_m % 10)};
      end else begin
        r_dig = 16'($urandom());
      end
      single(r_who, r_tgt, r_dig);
    end

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
